// File: rtl/sense_trace_ctrl.sv
// Capture sequencer for one delay-line sensor: settle, record popcounts of N
// consecutive readings into a trace buffer, then stream them out valid/ready.
module sense_trace_ctrl #(
  parameter int LINELEN = 64,
  parameter int DEPTH   = 256,
  parameter int SETTLE  = 4,
  localparam int PW     = $clog2(LINELEN + 1),
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clkin,
  input  logic               rstin,
  input  logic               trig_in,
  input  logic [AW-1:0]      nsamp,
  input  logic [LINELEN-1:0] sensor_val,
  output logic               sensor_ena,
  output logic               busy,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [PW-1:0]      rd_data,
  output logic               rd_last,
  output logic               cal_low,
  output logic               cal_high
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_READOUT} state_t;

  state_t          state_q, state_d;
  logic            ena_q, ena_d;
  logic [AW:0]     n_q, n_d;
  logic [SW-1:0]   set_cnt_q, set_cnt_d;
  logic [AW:0]     cap_cnt_q, cap_cnt_d;
  logic [PW-1:0]   pc_q, pc_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [AW:0]     fetch_q, fetch_d;
  logic            rd_valid_q, rd_valid_d;
  logic            rd_last_q, rd_last_d;
  logic [PW-1:0]   rd_data_q;
  logic            rd_load;
  logic            cal_low_q, cal_low_d;
  logic            cal_high_q, cal_high_d;
  logic [PW-1:0]   pc_now;

  logic [PW-1:0]   mem [DEPTH];

  function automatic logic [PW-1:0] popcnt(input logic [LINELEN-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < LINELEN; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  always_comb pc_now = popcnt(sensor_val);

  always_comb begin
    state_d    = state_q;
    ena_d      = ena_q;
    n_d        = n_q;
    set_cnt_d  = set_cnt_q;
    cap_cnt_d  = cap_cnt_q;
    pc_d       = pc_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    fetch_d    = fetch_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_load    = 1'b0;
    cal_low_d  = cal_low_q;
    cal_high_d = cal_high_q;
    case (state_q)
      S_IDLE: begin
        if (trig_in) begin
          state_d    = S_SETTLE;
          ena_d      = 1'b1;
          n_d        = (nsamp == '0) ? DEPTH_W : {1'b0, nsamp};
          set_cnt_d  = '0;
          cap_cnt_d  = '0;
          cal_low_d  = 1'b0;
          cal_high_d = 1'b0;
        end
      end
      S_SETTLE: begin
        set_cnt_d = set_cnt_q + 1'b1;
        if (set_cnt_q == SW'(SETTLE - 1)) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (cap_cnt_q != n_q) begin
          pc_d      = pc_now;
          wr_en_d   = 1'b1;
          wr_addr_d = cap_cnt_q[AW-1:0];
          cap_cnt_d = cap_cnt_q + 1'b1;
          if (pc_now == '0) cal_low_d = 1'b1;
          if (pc_now == PW'(LINELEN)) cal_high_d = 1'b1;
          if (cap_cnt_q == n_q - 1'b1) ena_d = 1'b0;
        end else begin
          // Drain cycle: the last popcount is written at this edge.
          state_d    = S_READOUT;
          fetch_d    = '0;
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
        end
      end
      S_READOUT: begin
        // The output register doubles as the buffer read register; it only
        // advances when empty or when the current word is accepted.
        if (!rd_valid_q || rd_ready) begin
          if (fetch_q != n_q) begin
            rd_load    = 1'b1;
            rd_valid_d = 1'b1;
            rd_last_d  = (fetch_q == n_q - 1'b1);
            fetch_d    = fetch_q + 1'b1;
          end else begin
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rstin) begin
      state_q    <= S_IDLE;
      ena_q      <= 1'b0;
      n_q        <= '0;
      set_cnt_q  <= '0;
      cap_cnt_q  <= '0;
      pc_q       <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      fetch_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      cal_low_q  <= 1'b0;
      cal_high_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ena_q      <= ena_d;
      n_q        <= n_d;
      set_cnt_q  <= set_cnt_d;
      cap_cnt_q  <= cap_cnt_d;
      pc_q       <= pc_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      fetch_q    <= fetch_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      cal_low_q  <= cal_low_d;
      cal_high_q <= cal_high_d;
      if (rd_load) rd_data_q <= mem[fetch_q[AW-1:0]];
    end
  end

  always_ff @(posedge clkin) begin
    if (wr_en_q) mem[wr_addr_q] <= pc_q;
  end

  assign sensor_ena = ena_q;
  assign busy       = (state_q != S_IDLE);
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign rd_last    = rd_last_q;
  assign cal_low    = cal_low_q;
  assign cal_high   = cal_high_q;

endmodule

// File: tb/tb_sense_trace_ctrl.sv
// Directed bench for sense_trace_ctrl: capture/readout traces, calibration
// flags, stalls, ignored triggers and mid-operation resets.
module tb_sense_trace_ctrl;
  localparam int LINELEN = 64;
  localparam int DEPTH   = 256;
  localparam int SETTLE  = 4;
  localparam int PW      = 7;
  localparam int AW      = 8;

  logic               clkin = 1'b0;
  logic               rstin;
  logic               trig_in;
  logic [AW-1:0]      nsamp;
  logic [LINELEN-1:0] sensor_val;
  logic               sensor_ena, busy, rd_valid, rd_ready, rd_last, cal_low, cal_high;
  logic [PW-1:0]      rd_data;

  int pass = 0;
  int total = 0;

  logic [63:0] sv_tab [256];
  int          got    [256];

  always #5 clkin = ~clkin;

  sense_trace_ctrl #(.LINELEN(LINELEN), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clkin(clkin), .rstin(rstin), .trig_in(trig_in), .nsamp(nsamp),
    .sensor_val(sensor_val), .sensor_ena(sensor_ena), .busy(busy),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .cal_low(cal_low), .cal_high(cal_high)
  );

  // Triggers a trace and feeds sv_tab[j] for the j-th captured cycle.
  // Starts and ends just after a falling edge; ends in the drain cycle.
  task automatic do_capture(input int n, input bit noise, output int ena_cyc,
                            output logic [1:0] cal0);
    int k, j;
    k = 0;
    cal0 = 2'bxx;
    nsamp = n[AW-1:0];
    trig_in = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clkin);
      trig_in = 1'b0;
      if (sensor_ena) begin
        k++;
        if (k == 1) cal0 = {cal_low, cal_high};
        j = k - SETTLE - 1;
        if (j >= 0 && j < 256) sensor_val = sv_tab[j];
        if (noise && (k == 2 || k == SETTLE + 2)) trig_in = 1'b1;
      end else if (k > 0) begin
        break;
      end
    end
    ena_cyc = k;
  endtask

  // Drains the readout port; mode 0 = always ready, 1 = random ready.
  task automatic collect(input int mode, input bit noise, input bit trig_last,
                         input int stop_after, output int cnt, output int lastidx,
                         output int lat, output int unstable);
    bit rdy, pstall, pl;
    int pd;
    cnt = 0; lastidx = -1; lat = -1; unstable = 0; pstall = 0; pd = 0; pl = 0;
    for (int c = 1; c < 5000; c++) begin
      @(negedge clkin);
      trig_in = 1'b0;
      if (pstall && (!rd_valid || int'(rd_data) != pd || rd_last != pl)) unstable++;
      if (rd_valid && lat < 0) lat = c;
      rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      rd_ready = rdy;
      if (noise && c == 3) trig_in = 1'b1;
      pstall = rd_valid && !rdy;
      pd = int'(rd_data);
      pl = rd_last;
      if (rd_valid && rdy) begin
        if (cnt < 256) got[cnt] = int'(rd_data);
        if (rd_last) begin
          lastidx = cnt;
          cnt++;
          if (trig_last) trig_in = 1'b1;
          break;
        end
        cnt++;
        if (cnt == stop_after || cnt > 300) break;
      end
    end
  endtask

  task automatic test_reset;
    rstin = 1'b1; trig_in = 1'b0; nsamp = '0; sensor_val = '0; rd_ready = 1'b0;
    repeat (3) @(negedge clkin);
    total++;
    if ({sensor_ena, busy, rd_valid, rd_last, cal_low, cal_high, rd_data} !== '0)
      $display("FAIL reset_outputs: got %b want 0",
               {sensor_ena, busy, rd_valid, rd_last, cal_low, cal_high, rd_data});
    else pass++;
    rstin = 1'b0;
    @(negedge clkin);
  endtask

  task automatic test_basic;
    int ena, cnt, li, lat, un;
    logic [1:0] c0;
    for (int i = 0; i < 4; i++) sv_tab[i] = 64'h0000_0000_FFFF_FFFF;
    do_capture(4, 0, ena, c0);
    total++; if (ena !== 8) $display("FAIL basic_ena_cycles: got %0d want 8", ena); else pass++;
    collect(0, 0, 0, 0, cnt, li, lat, un);
    total++; if (lat < 1 || lat > 2) $display("FAIL basic_valid_latency: got %0d want 1..2", lat); else pass++;
    total++; if (cnt !== 4) $display("FAIL basic_count: got %0d want 4", cnt); else pass++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got[i] !== 32) $display("FAIL basic_data%0d: got %0d want 32", i, got[i]); else pass++;
    end
    total++; if (li !== 3) $display("FAIL basic_last_idx: got %0d want 3", li); else pass++;
    @(negedge clkin);
    total++;
    if ({busy, rd_valid, sensor_ena} !== 3'b000)
      $display("FAIL basic_idle_after: busy/valid/ena got %b want 000", {busy, rd_valid, sensor_ena});
    else pass++;
    total++;
    if ({cal_low, cal_high} !== 2'b00) $display("FAIL basic_cal: got %b want 00", {cal_low, cal_high}); else pass++;
  endtask

  task automatic test_cal;
    int ena, cnt, li, lat, un;
    logic [1:0] c0;
    sv_tab[0] = 64'h0;
    sv_tab[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    sv_tab[2] = 64'h0F;
    do_capture(3, 0, ena, c0);
    collect(0, 0, 0, 0, cnt, li, lat, un);
    total++;
    if (cnt !== 3 || got[0] !== 0 || got[1] !== 64 || got[2] !== 4)
      $display("FAIL cal_data: got n=%0d %0d,%0d,%0d want n=3 0,64,4", cnt, got[0], got[1], got[2]);
    else pass++;
    @(negedge clkin);
    total++;
    if ({cal_low, cal_high} !== 2'b11) $display("FAIL cal_sticky: got %b want 11", {cal_low, cal_high}); else pass++;
    sv_tab[0] = 64'h0000_0000_FFFF_FFFF;
    do_capture(1, 0, ena, c0);
    total++;
    if (c0 !== 2'b00) $display("FAIL cal_clear_on_trig: got %b want 00", c0); else pass++;
    collect(0, 0, 0, 0, cnt, li, lat, un);
    total++;
    if (cnt !== 1 || got[0] !== 32 || li !== 0)
      $display("FAIL cal_single: got n=%0d d=%0d last=%0d want 1,32,0", cnt, got[0], li);
    else pass++;
    @(negedge clkin);
  endtask

  task automatic test_full_depth;
    int ena, cnt, li, lat, un, bad;
    logic [1:0] c0;
    logic [7:0] b;
    for (int j = 0; j < 256; j++) begin
      b = j[7:0];
      sv_tab[j] = {8{b}};
    end
    do_capture(0, 0, ena, c0);
    total++; if (ena !== SETTLE + 256) $display("FAIL full_ena_cycles: got %0d want %0d", ena, SETTLE + 256); else pass++;
    collect(0, 0, 0, 0, cnt, li, lat, un);
    total++; if (cnt !== 256) $display("FAIL full_count: got %0d want 256", cnt); else pass++;
    bad = 0;
    for (int j = 0; j < 256; j++) begin
      b = j[7:0];
      if (got[j] !== 8 * $countones(b)) bad++;
    end
    total++; if (bad !== 0) $display("FAIL full_data: got %0d wrong entries want 0", bad); else pass++;
    total++; if (li !== 255) $display("FAIL full_last_idx: got %0d want 255", li); else pass++;
    @(negedge clkin);
    total++;
    if ({cal_low, cal_high, busy} !== 3'b110) $display("FAIL full_cal_busy: got %b want 110", {cal_low, cal_high, busy}); else pass++;
  endtask

  task automatic test_stall;
    int ena, cnt, li, lat, un, bad, k;
    logic [1:0] c0;
    logic [63:0] one;
    one = 64'h1;
    for (int i = 0; i < 20; i++) begin
      k = (i * 7) % 65;
      sv_tab[i] = (one << k) - 64'h1;
    end
    do_capture(20, 0, ena, c0);
    collect(1, 0, 0, 0, cnt, li, lat, un);
    total++; if (cnt !== 20 || li !== 19) $display("FAIL stall_count: got n=%0d last=%0d want 20,19", cnt, li); else pass++;
    bad = 0;
    for (int i = 0; i < 20; i++) if (got[i] !== (i * 7) % 65) bad++;
    total++; if (bad !== 0) $display("FAIL stall_data: got %0d wrong entries want 0", bad); else pass++;
    total++; if (un !== 0) $display("FAIL stall_stable: got %0d changes while stalled want 0", un); else pass++;
    @(negedge clkin);
  endtask

  task automatic test_ignore_trig;
    int ena, cnt, li, lat, un, viol;
    logic [1:0] c0;
    sv_tab[0] = 64'h1; sv_tab[1] = 64'h3; sv_tab[2] = 64'h7;
    do_capture(3, 1, ena, c0);
    total++; if (ena !== SETTLE + 3) $display("FAIL ign_ena_cycles: got %0d want %0d", ena, SETTLE + 3); else pass++;
    collect(0, 1, 0, 0, cnt, li, lat, un);
    total++;
    if (cnt !== 3 || got[0] !== 1 || got[1] !== 2 || got[2] !== 3)
      $display("FAIL ign_data: got n=%0d %0d,%0d,%0d want n=3 1,2,3", cnt, got[0], got[1], got[2]);
    else pass++;
    viol = 0;
    repeat (6) begin
      @(negedge clkin);
      if (busy || sensor_ena || rd_valid) viol++;
    end
    total++; if (viol !== 0) $display("FAIL ign_one_trace: got %0d busy cycles want 0", viol); else pass++;
  endtask

  task automatic test_back_to_back;
    int ena, cnt, li, lat, un;
    logic [1:0] c0;
    sv_tab[0] = 64'hFF; sv_tab[1] = 64'hFFFF; sv_tab[2] = 64'hF;
    do_capture(2, 0, ena, c0);
    collect(0, 0, 1, 0, cnt, li, lat, un);
    @(negedge clkin);
    trig_in = 1'b0;
    total++;
    if ({busy, sensor_ena} !== 2'b00) $display("FAIL b2b_trig_on_last_ignored: got %b want 00", {busy, sensor_ena}); else pass++;
    do_capture(3, 0, ena, c0);
    total++; if (ena !== SETTLE + 3) $display("FAIL b2b_next_trig: got %0d want %0d", ena, SETTLE + 3); else pass++;
    collect(0, 0, 0, 0, cnt, li, lat, un);
    total++;
    if (cnt !== 3 || got[0] !== 8 || got[1] !== 16 || got[2] !== 4)
      $display("FAIL b2b_data: got n=%0d %0d,%0d,%0d want n=3 8,16,4", cnt, got[0], got[1], got[2]);
    else pass++;
    @(negedge clkin);
  endtask

  task automatic test_reset_mid;
    int ena, cnt, li, lat, un;
    logic [1:0] c0;
    sensor_val = 64'hFFFF_FFFF_FFFF_FFFF;
    nsamp = 8'd10;
    trig_in = 1'b1;
    @(negedge clkin);
    trig_in = 1'b0;
    repeat (SETTLE + 3) @(negedge clkin);
    rstin = 1'b1;
    @(negedge clkin);
    total++;
    if ({sensor_ena, busy, rd_valid, rd_last, cal_low, cal_high, rd_data} !== '0)
      $display("FAIL rst_mid_capture: got %b want 0",
               {sensor_ena, busy, rd_valid, rd_last, cal_low, cal_high, rd_data});
    else pass++;
    rstin = 1'b0;
    sv_tab[0] = 64'h3F; sv_tab[1] = 64'h1;
    do_capture(2, 0, ena, c0);
    collect(0, 0, 0, 0, cnt, li, lat, un);
    total++;
    if (cnt !== 2 || got[0] !== 6 || got[1] !== 1 || li !== 1)
      $display("FAIL rst_fresh1: got n=%0d %0d,%0d last=%0d want 2 6,1 last=1", cnt, got[0], got[1], li);
    else pass++;
    @(negedge clkin);
    for (int i = 0; i < 8; i++) sv_tab[i] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_capture(8, 0, ena, c0);
    collect(0, 0, 0, 3, cnt, li, lat, un);
    rstin = 1'b1;
    @(negedge clkin);
    total++;
    if ({sensor_ena, busy, rd_valid, rd_last, cal_low, cal_high, rd_data} !== '0)
      $display("FAIL rst_mid_readout: got %b want 0",
               {sensor_ena, busy, rd_valid, rd_last, cal_low, cal_high, rd_data});
    else pass++;
    rstin = 1'b0;
    sv_tab[0] = 64'h0; sv_tab[1] = 64'h7F;
    do_capture(2, 0, ena, c0);
    collect(0, 0, 0, 0, cnt, li, lat, un);
    total++;
    if (cnt !== 2 || got[0] !== 0 || got[1] !== 7 || li !== 1)
      $display("FAIL rst_fresh2: got n=%0d %0d,%0d last=%0d want 2 0,7 last=1", cnt, got[0], got[1], li);
    else pass++;
    @(negedge clkin);
    total++;
    if ({cal_low, cal_high} !== 2'b10) $display("FAIL rst_fresh2_cal: got %b want 10", {cal_low, cal_high}); else pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cal();
    test_full_depth();
    test_stall();
    test_ignore_trig();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
